// File: rtl/perf_counter_arbiter_pkg.sv
// Shared types for the performance-counter arbiter: 64-bit data words, the
// result record layout, the per-channel FSM encoding and a saturating adder.
// No ports; imported by perf_channel_tracker and perf_counter_arbiter.
package perf_counter_arbiter_pkg;

  typedef logic [63:0] data64_t;

  // Widest channel index supported (N_CH up to 16).
  localparam int unsigned MAX_CH_W = 4;

  // Record as seen by a consumer of the output port.
  typedef struct packed {
    logic [MAX_CH_W-1:0] channel;
    data64_t             cycles;
    data64_t             idle;
  } perf_record_t;

  typedef enum logic {
    ST_WAIT     = 1'b0,
    ST_COUNTING = 1'b1
  } ch_state_e;

  // Unsigned add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add_u32(input logic [31:0] a, input logic [4:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {28'd0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/perf_channel_tracker.sv
// Per-channel measurement FSM with 64-bit cycle/idle counters and a one-deep result slot.
// Latency: a completing beat lands in the slot (pend_o) at the next edge.
// Backpressure: a completion while the slot is full and not granted is dropped (drop_o pulse).
// Ports: clk/rst, clear_i (abort+flush), enable_i, hs_i/last_i (stream beat),
//        grant_i (slot taken this edge), busy_o, pend_o, pend_cycles_o/pend_idle_o, drop_o.
module perf_channel_tracker
  import perf_counter_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear_i,
  input  logic    enable_i,
  input  logic    hs_i,
  input  logic    last_i,
  input  logic    grant_i,
  output logic    busy_o,
  output logic    pend_o,
  output data64_t pend_cycles_o,
  output data64_t pend_idle_o,
  output logic    drop_o
);

  ch_state_e state_q;
  data64_t   cycles_q, idle_q;
  data64_t   slot_cycles_q, slot_idle_q;
  logic      pend_q;

  logic      start, done;
  data64_t   cycles_d, idle_d;

  // Counter next-values; on a completing beat these are the values recorded,
  // so the final cycle is already folded in.
  always_comb begin
    start    = 1'b0;
    done     = 1'b0;
    cycles_d = cycles_q;
    idle_d   = idle_q;
    case (state_q)
      ST_WAIT: begin
        if (enable_i && hs_i) begin
          start    = 1'b1;
          cycles_d = 64'd1;
          idle_d   = '0;
          done     = last_i;
        end
      end
      ST_COUNTING: begin
        cycles_d = cycles_q + 64'd1;
        idle_d   = idle_q + {63'd0, ~hs_i};
        done     = hs_i & last_i;
      end
      default: ;
    endcase
  end

  // A granted slot empties on this edge, so a same-edge completion refills it.
  assign drop_o = done & pend_q & ~grant_i & ~clear_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT;
      cycles_q      <= '0;
      idle_q        <= '0;
      slot_cycles_q <= '0;
      slot_idle_q   <= '0;
      pend_q        <= 1'b0;
    end else if (clear_i) begin
      state_q  <= ST_WAIT;
      cycles_q <= '0;
      idle_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      cycles_q <= cycles_d;
      idle_q   <= idle_d;
      case (state_q)
        ST_WAIT:     if (start && !done) state_q <= ST_COUNTING;
        ST_COUNTING: if (done) state_q <= ST_WAIT;
        default:     state_q <= ST_WAIT;
      endcase
      if (done && (!pend_q || grant_i)) begin
        slot_cycles_q <= cycles_d;
        slot_idle_q   <= idle_d;
        pend_q        <= 1'b1;
      end else if (grant_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign busy_o        = (state_q == ST_COUNTING);
  assign pend_o        = pend_q;
  assign pend_cycles_o = slot_cycles_q;
  assign pend_idle_o   = slot_idle_q;

endmodule

// File: rtl/perf_counter_arbiter.sv
// Measures per-channel stream transfers and serialises results through a round-robin output register.
// Latency: completion in cycle c gives out_valid at the earliest in cycle c+2.
// Backpressure: out_ready low holds the record; one pending slot per channel, further completions drop.
// Ports: clk/rst, cfg_enable, cfg_clear, ch_handshake/ch_last [N_CH], out_valid/out_ready,
//        out_channel, out_cycles, out_idle, busy [N_CH], drop_count (saturating).
module perf_counter_arbiter
  import perf_counter_arbiter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_enable,
  input  logic            cfg_clear,
  input  logic [N_CH-1:0] ch_handshake,
  input  logic [N_CH-1:0] ch_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_channel,
  output data64_t         out_cycles,
  output data64_t         out_idle,
  output logic [N_CH-1:0] busy,
  output logic [31:0]     drop_count
);

  logic [N_CH-1:0] pend_vec;
  logic [N_CH-1:0] drop_vec;
  logic [N_CH-1:0] grant_vec;
  data64_t         pend_cycles [N_CH];
  data64_t         pend_idle   [N_CH];

  logic            out_vld_q;
  logic [CH_W-1:0] out_chan_q;
  data64_t         out_cyc_q, out_idle_q;
  logic [CH_W-1:0] ptr_q;
  logic [31:0]     drop_q;

  logic            ld_en;
  logic            win_vld;
  logic [CH_W-1:0] win_idx;
  logic [CH_W-1:0] rr_idx;
  logic [4:0]      drop_inc;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign grant_vec[g] = ld_en & win_vld & (win_idx == CH_W'(g));

    perf_channel_tracker u_trk (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (cfg_clear),
      .enable_i      (cfg_enable),
      .hs_i          (ch_handshake[g]),
      .last_i        (ch_last[g]),
      .grant_i       (grant_vec[g]),
      .busy_o        (busy[g]),
      .pend_o        (pend_vec[g]),
      .pend_cycles_o (pend_cycles[g]),
      .pend_idle_o   (pend_idle[g]),
      .drop_o        (drop_vec[g])
    );
  end

  // The register may load when empty or being drained; a clear cycle never loads.
  assign ld_en = (~out_vld_q | out_ready) & ~cfg_clear;

  // Round-robin: search from the channel after the last grant, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_idx  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      rr_idx = CH_W'((int'(ptr_q) + i) % N_CH);
      if (!win_vld && pend_vec[rr_idx]) begin
        win_vld = 1'b1;
        win_idx = rr_idx;
      end
    end
  end

  // Several channels may drop on the same edge.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_inc = drop_inc + {4'd0, drop_vec[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_chan_q <= '0;
      out_cyc_q  <= '0;
      out_idle_q <= '0;
      ptr_q      <= CH_W'(N_CH - 1);
      drop_q     <= '0;
    end else if (cfg_clear) begin
      out_vld_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (ld_en) begin
        out_vld_q <= win_vld;
        if (win_vld) begin
          out_chan_q <= win_idx;
          out_cyc_q  <= pend_cycles[win_idx];
          out_idle_q <= pend_idle[win_idx];
          ptr_q      <= win_idx;
        end
      end
      drop_q <= sat_add_u32(drop_q, drop_inc);
    end
  end

  assign out_valid   = out_vld_q;
  assign out_channel = out_chan_q;
  assign out_cycles  = out_cyc_q;
  assign out_idle    = out_idle_q;
  assign drop_count  = drop_q;

endmodule

// File: doc/perf_counter_arbiter.md
PERF_COUNTER_ARBITER -- requirements
Module: perf_counter_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, giving the number of measured channels (range 2..16).
REQ-002 SHALL have parameter CH_W, default $clog2(N_CH), giving the channel-index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_enable, input, 1 bit: when high, channels may start new measurements.
REQ-006 SHALL have port cfg_clear, input, 1 bit: single-cycle pulse that aborts all measurements and flushes results.
REQ-007 SHALL have port ch_handshake, input, N_CH bits: per-channel stream handshake (valid & ready) this cycle.
REQ-008 SHALL have port ch_last, input, N_CH bits: per-channel last beat, qualified by ch_handshake.
REQ-009 SHALL have port out_valid, output, 1 bit: a result record is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the record.
REQ-011 SHALL have port out_channel, output, CH_W bits: index of the channel that produced the record.
REQ-012 SHALL have port out_cycles, output, 64 bits (data64_t): total measured cycles.
REQ-013 SHALL have port out_idle, output, 64 bits (data64_t): measured cycles without a handshake.
REQ-014 SHALL have port busy, output, N_CH bits: the channel is in state COUNTING.
REQ-015 SHALL have port drop_count, output, 32 bits: saturating count of results discarded.

Function
REQ-016 Each channel SHALL have a 2-state FSM: WAIT, COUNTING.
REQ-017 In WAIT with cfg_enable=1 and handshake=1: cycles:=1, idle:=0; if last=1, complete now; else go to COUNTING.
REQ-018 In WAIT with cfg_enable=0: handshakes ignored, no state change.
REQ-019 In COUNTING each cycle: cycles+=1; idle+=1 if handshake=0; cfg_enable has no effect.
REQ-020 In COUNTING, handshake=1 with last=1 SHALL complete; the final cycle is included in cycles; go to WAIT.
REQ-021 ch_last without ch_handshake SHALL be ignored in both states.
REQ-022 Counters SHALL be 64-bit and wrap modulo 2^64 without a flag.
REQ-023 Completion SHALL latch {cycles, idle} into the channel's pending slot and set its pending bit at the next edge.
REQ-024 Completion while the channel's pending bit is already set (and not being granted that edge) SHALL discard the new result and increment drop_count, saturating at 2^32-1.
REQ-025 A single output register SHALL load when empty or when out_valid & out_ready; the source is the round-robin winner among pending slots.
REQ-026 Round-robin SHALL search starting at the index after the last granted channel; the pointer resets to N_CH-1, so channel 0 is searched first.
REQ-027 A granted slot's pending bit SHALL clear on the same edge the output register loads; a same-edge new completion on that channel SHALL refill the slot, with no drop.
REQ-028 Latency: completion in cycle c SHALL give out_valid high at the earliest in cycle c+2.
REQ-029 While out_valid=1 and out_ready=0, out_channel, out_cycles and out_idle SHALL hold stable.
REQ-030 Throughput SHALL be one record per cycle when out_ready is held high.
REQ-031 cfg_clear SHALL, at the next edge: force all FSMs to WAIT, clear pending bits and out_valid, and zero drop_count; completions in the clear cycle SHALL be discarded without counting as drops.

Reset
REQ-032 rst SHALL set: FSMs to WAIT, all counters and slots to 0, pending to 0, out_valid=0, out_channel/out_cycles/out_idle=0, busy=0, drop_count=0, RR pointer=N_CH-1.
REQ-033 rst asserted mid-measurement SHALL abandon it with no record emitted; rst takes priority over cfg_clear.

Structure
REQ-034 data64_t and a packed perf_record_t {channel, cycles, idle} SHALL reside in the shared util package.
REQ-035 The per-channel FSM, counters and pending slot SHALL be sub-module perf_channel_tracker, instantiated N_CH times; the arbiter and output register SHALL live in the top module.

Verification
REQ-036 Ch0: handshake+last in one cycle, enable=1 -> one record: channel 0, cycles=1, idle=0, out_valid 2 cycles later.
REQ-037 Ch1: handshakes on 4 of 6 consecutive cycles, last on the 6th -> cycles=6, idle=2.
REQ-038 Ch0..3 complete in the same cycle, out_ready=1 -> records on 4 consecutive cycles in order 0,1,2,3; then ch2 and ch0 complete together -> order 2,0 is wrong and 0,2 is required only if the pointer is at 3; check against the pointer.
REQ-039 out_ready=0; ch0 completes 3 times -> out_valid holds the first record, the second is pending, the third drops; drop_count=1.
REQ-040 cfg_enable=0 handshake ignored (busy stays 0); cfg_clear during COUNTING -> busy=0, out_valid=0, and no record ever appears.
